sdram_responder: RTL and testbench

- Synthesizable single-chip SDR SDRAM responder: the device side of the 16-bit SDRAM command bus that our controllers drive.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows, and serves reads and writes from a small internal array with programmable CAS latency.
- Checks protocol and timing and raises sticky error flags. Used as an on-FPGA loopback target for controller bring-up and regression.

---
 rtl/sdram_responder_if.sv | 31 +++
 rtl/sdram_responder.sv | 245 ++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// SDR SDRAM command/data bus between a controller (master) and the responder (slave).
//   DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N : command strobes
//   DRAM_BA[1:0], DRAM_ADDR[12:0]                            : bank / row / column / mode value
//   DRAM_DQM[1:0]                                            : byte masks ([0] -> bits 7:0)
//   dq_in[15:0]                                              : write data from the controller
//   dq_out[15:0], dq_oe                                      : read data and its drive enable
interface sdram_responder_if;
    logic        DRAM_CKE;
    logic        DRAM_CS_N;
    logic        DRAM_RAS_N;
    logic        DRAM_CAS_N;
    logic        DRAM_WE_N;
    logic [1:0]  DRAM_BA;
    logic [12:0] DRAM_ADDR;
    logic [1:0]  DRAM_DQM;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;

    modport master (
        output DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
        output DRAM_BA, DRAM_ADDR, DRAM_DQM, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
        input  DRAM_BA, DRAM_ADDR, DRAM_DQM, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Device side of a 16-bit SDR SDRAM bus, used as an on-FPGA loopback target.
// Decodes commands, tracks per-bank open rows, serves reads/writes from a small array
// with programmable CAS latency (2 or 3) and flags protocol/timing errors (sticky).
//   CLOCK_100      : sole clock, rising edge
//   rst            : asynchronous active-high reset
//   bus            : SDRAM command/data bus (slave modport)
//   mode_set       : MRS accepted since reset
//   err_seq        : illegal command sequence
//   err_timing     : T_RCD or T_RFC violated
//   err_bus        : WRITE issued while read data was still pending
//   err_mode       : unsupported mode-register value
//   refresh_count  : REF commands seen, saturating
module sdram_responder #(
    parameter int unsigned ROW_KEEP = 2,
    parameter int unsigned COL_KEEP = 6,
    parameter int unsigned T_RCD    = 2,
    parameter int unsigned T_RFC    = 6
) (
    input  logic                CLOCK_100,
    input  logic                rst,
    sdram_responder_if.slave    bus,
    output logic                mode_set,
    output logic                err_seq,
    output logic                err_timing,
    output logic                err_bus,
    output logic                err_mode,
    output logic [15:0]         refresh_count
);
    localparam int unsigned IdxW = 2 + ROW_KEEP + COL_KEEP;

    typedef enum logic [2:0] {
        CmdNop, CmdAct, CmdRead, CmdWrite, CmdPre, CmdRef, CmdMrs, CmdBst
    } cmd_e;

    cmd_e                  cmd;
    logic [1:0]            ba;
    logic [12:0]           addr;
    logic [IdxW-1:0]       idx;
    logic [15:0]           rd_word, rd_masked;

    logic [3:0]            open_q, open_d;
    logic [3:0][12:0]      row_q, row_d;
    logic [3:0][7:0]       rcd_q, rcd_d;
    logic [7:0]            rfc_q, rfc_d;
    logic [1:0]            cl_q, cl_d;
    logic                  mode_set_q, mode_set_d;
    logic                  err_seq_q, err_seq_d;
    logic                  err_timing_q, err_timing_d;
    logic                  err_bus_q, err_bus_d;
    logic                  err_mode_q, err_mode_d;
    logic [15:0]           ref_cnt_q, ref_cnt_d;
    // Read pipeline: slot 0 loads the output register on the next edge, slot 1 one edge later.
    logic [1:0]            p_vld_q, p_vld_d;
    logic [1:0][15:0]      p_data_q, p_data_d;
    logic                  oe_q, oe_d;
    logic [15:0]           dout_q, dout_d;
    logic                  ld_pipe, do_write;
    logic                  unused_rows;

    logic [15:0]           mem [2**IdxW];

    assign ba   = bus.DRAM_BA;
    assign addr = bus.DRAM_ADDR;
    assign idx  = {ba, row_q[ba][ROW_KEEP-1:0], addr[COL_KEEP-1:0]};
    assign rd_word   = mem[idx];
    assign rd_masked = {bus.DRAM_DQM[1] ? 8'h00 : rd_word[15:8],
                        bus.DRAM_DQM[0] ? 8'h00 : rd_word[7:0]};
    // Full row is tracked for visibility; only the low bits reach the storage index.
    assign unused_rows = ^row_q;

    always_comb begin
        cmd = CmdNop;
        if (bus.DRAM_CKE && !bus.DRAM_CS_N) begin
            unique case ({bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N})
                3'b111:  cmd = CmdNop;
                3'b011:  cmd = CmdAct;
                3'b101:  cmd = CmdRead;
                3'b100:  cmd = CmdWrite;
                3'b010:  cmd = CmdPre;
                3'b001:  cmd = CmdRef;
                3'b000:  cmd = CmdMrs;
                3'b110:  cmd = CmdBst;
                default: cmd = CmdNop;
            endcase
        end
    end

    always_comb begin
        open_d       = open_q;
        row_d        = row_q;
        cl_d         = cl_q;
        mode_set_d   = mode_set_q;
        err_seq_d    = err_seq_q;
        err_timing_d = err_timing_q;
        err_bus_d    = err_bus_q;
        err_mode_d   = err_mode_q;
        ref_cnt_d    = ref_cnt_q;
        ld_pipe      = 1'b0;
        do_write     = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rcd_d[b] = (rcd_q[b] != 8'd0) ? rcd_q[b] - 8'd1 : 8'd0;
        end
        rfc_d = (rfc_q != 8'd0) ? rfc_q - 8'd1 : 8'd0;

        if (cmd != CmdNop && rfc_q != 8'd0) begin
            err_timing_d = 1'b1;
        end

        unique case (cmd)
            CmdAct: begin
                if (!mode_set_q || open_q[ba]) begin
                    err_seq_d = 1'b1;
                end else begin
                    open_d[ba] = 1'b1;
                    row_d[ba]  = addr;
                    rcd_d[ba]  = 8'(T_RCD - 1);
                end
            end
            CmdRead, CmdWrite: begin
                if (!mode_set_q || !open_q[ba]) begin
                    err_seq_d = 1'b1;
                end else begin
                    if (rcd_q[ba] != 8'd0) begin
                        err_timing_d = 1'b1;
                    end
                    if (cmd == CmdRead) begin
                        ld_pipe = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        if (|p_vld_q || oe_q) begin
                            err_bus_d = 1'b1;
                        end
                    end
                    if (addr[10]) begin
                        open_d[ba] = 1'b0;
                    end
                end
            end
            CmdPre: begin
                if (addr[10]) begin
                    open_d = '0;
                end else begin
                    open_d[ba] = 1'b0;
                end
            end
            CmdRef: begin
                if (ref_cnt_q != 16'hFFFF) begin
                    ref_cnt_d = ref_cnt_q + 16'd1;
                end
                if (|open_q) begin
                    err_seq_d = 1'b1;
                end else begin
                    rfc_d = 8'(T_RFC - 1);
                end
            end
            CmdMrs: begin
                if (|open_q) begin
                    err_seq_d = 1'b1;
                end else begin
                    mode_set_d = 1'b1;
                    if (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) begin
                        cl_d = addr[5:4];
                    end else begin
                        err_mode_d = 1'b1;
                    end
                    if (addr[2:0] != 3'd0) begin
                        err_mode_d = 1'b1;
                    end
                end
            end
            CmdBst:  err_seq_d = 1'b1;
            default: ;
        endcase

        // Entries carry their own position, so a later CL change cannot retime them.
        p_vld_d[0]  = p_vld_q[1];
        p_data_d[0] = p_data_q[1];
        p_vld_d[1]  = 1'b0;
        p_data_d[1] = p_data_q[1];
        if (ld_pipe) begin
            if (cl_q == 2'd2) begin
                p_vld_d[0]  = 1'b1;
                p_data_d[0] = rd_masked;
            end else begin
                p_vld_d[1]  = 1'b1;
                p_data_d[1] = rd_masked;
            end
        end
        oe_d   = p_vld_q[0];
        dout_d = p_vld_q[0] ? p_data_q[0] : dout_q;
    end

    always_ff @(posedge CLOCK_100 or posedge rst) begin
        if (rst) begin
            open_q       <= '0;
            row_q        <= '0;
            rcd_q        <= '0;
            rfc_q        <= '0;
            cl_q         <= 2'd3;
            mode_set_q   <= 1'b0;
            err_seq_q    <= 1'b0;
            err_timing_q <= 1'b0;
            err_bus_q    <= 1'b0;
            err_mode_q   <= 1'b0;
            ref_cnt_q    <= '0;
            p_vld_q      <= '0;
            p_data_q     <= '0;
            oe_q         <= 1'b0;
            dout_q       <= '0;
        end else begin
            open_q       <= open_d;
            row_q        <= row_d;
            rcd_q        <= rcd_d;
            rfc_q        <= rfc_d;
            cl_q         <= cl_d;
            mode_set_q   <= mode_set_d;
            err_seq_q    <= err_seq_d;
            err_timing_q <= err_timing_d;
            err_bus_q    <= err_bus_d;
            err_mode_q   <= err_mode_d;
            ref_cnt_q    <= ref_cnt_d;
            p_vld_q      <= p_vld_d;
            p_data_q     <= p_data_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLOCK_100) begin
        if (do_write) begin
            if (!bus.DRAM_DQM[0]) mem[idx][7:0]  <= bus.dq_in[7:0];
            if (!bus.DRAM_DQM[1]) mem[idx][15:8] <= bus.dq_in[15:8];
        end
    end

    assign bus.dq_out    = dout_q;
    assign bus.dq_oe     = oe_q;
    assign mode_set      = mode_set_q;
    assign err_seq       = err_seq_q;
    assign err_timing    = err_timing_q;
    assign err_bus       = err_bus_q;
    assign err_mode      = err_mode_q;
    assign refresh_count = ref_cnt_q;
endmodule

// File: tb/tb_sdram_responder.sv
module tb_sdram_responder;
    localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
    localparam logic [2:0] PRE = 3'b010, REF = 3'b001, MRS = 3'b000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_responder_if bus ();
    logic        mode_set, err_seq, err_timing, err_bus, err_mode;
    logic [15:0] refresh_count;

    sdram_responder dut (
        .CLOCK_100     (clk),
        .rst           (rst),
        .bus           (bus),
        .mode_set      (mode_set),
        .err_seq       (err_seq),
        .err_timing    (err_timing),
        .err_bus       (err_bus),
        .err_mode      (err_mode),
        .refresh_count (refresh_count)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   oe_cnt = 0;
    int   cl_model = 3;
    int   oe_before;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with dq_oe high must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.dq_oe === 1'b1) begin
            oe_cnt++;
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_read: dq_out=%h at cycle %0d, none expected",
                         bus.dq_out, cyc);
            end else begin
                e = q.pop_front();
                if (bus.dq_out !== e.data || cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d",
                             bus.dq_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm = 2'b00, input logic [15:0] d = 16'h0000);
        bus.DRAM_CS_N = 1'b0;
        {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = c;
        bus.DRAM_BA   = ba;
        bus.DRAM_ADDR = addr;
        bus.DRAM_DQM  = dqm;
        bus.dq_in     = d;
        @(posedge clk);
        #1;
        {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = NOP;
        bus.DRAM_DQM = 2'b00;
    endtask

    task automatic nop(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] ba, input logic [5:0] col, input logic [1:0] dqm,
                      input logic [15:0] exp, input bit push = 1'b1);
        cmd(RD, ba, {7'd0, col}, dqm);
        if (push) q.push_back('{cyc + cl_model - 1, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop(2);
        rst = 1'b0;
        nop(1);
    endtask

    task automatic init();
        cmd(PRE, 2'd0, 13'h400);
        repeat (8) begin
            cmd(REF, 2'd0, 13'h000);
            nop(6);
        end
        cmd(MRS, 2'd0, 13'h030);
        cl_model = 3;
    endtask

    initial begin
        bus.DRAM_CKE  = 1'b1;
        bus.DRAM_CS_N = 1'b1;
        {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = NOP;
        bus.DRAM_BA   = 2'd0;
        bus.DRAM_ADDR = 13'h0;
        bus.DRAM_DQM  = 2'b00;
        bus.dq_in     = 16'h0;
        rst = 1'b1;
        nop(3);
        rst = 1'b0;
        nop(1);

        // Reset state
        check("rst_dq_oe", bus.dq_oe, 1'b0);
        check("rst_dq_out", bus.dq_out, 16'h0);
        check("rst_mode_set", mode_set, 1'b0);
        check("rst_errs", {err_seq, err_timing, err_bus, err_mode}, 4'b0);
        check("rst_refresh", refresh_count, 16'd0);

        // Init and mode set
        init();
        check("init_mode_set", mode_set, 1'b1);
        check("init_refresh", refresh_count, 16'd8);
        check("init_errs", {err_seq, err_timing, err_bus, err_mode}, 4'b0);

        // Write then read, CL=3
        cmd(ACT, 2'd1, 13'd5);
        nop(2);
        cmd(WR, 2'd1, 13'h010, 2'b00, 16'hBEEF);
        cmd(WR, 2'd1, 13'h011, 2'b00, 16'h1234);
        cmd(PRE, 2'd1, 13'h000);
        cmd(ACT, 2'd1, 13'd5);
        nop(2);
        oe_before = oe_cnt;
        rd(2'd1, 6'h10, 2'b00, 16'hBEEF);
        rd(2'd1, 6'h11, 2'b00, 16'h1234);
        nop(6);
        check("wr_rd_oe_cycles", oe_cnt - oe_before, 2);
        check("wr_rd_errs", {err_seq, err_timing, err_bus, err_mode}, 4'b0);

        // DQM masking
        cmd(WR, 2'd1, 13'h010, 2'b10, 16'hAAAA);
        nop(1);
        rd(2'd1, 6'h10, 2'b00, 16'hBEAA);
        rd(2'd1, 6'h10, 2'b01, 16'hBE00);
        nop(6);
        check("dqm_err_bus", err_bus, 1'b0);

        // WRITE colliding with pending read data still lands in the array
        rd(2'd1, 6'h11, 2'b00, 16'h1234);
        cmd(WR, 2'd1, 13'h013, 2'b00, 16'h5555);
        nop(5);
        rd(2'd1, 6'h13, 2'b00, 16'h5555);
        nop(6);
        check("collide_err_bus", err_bus, 1'b1);
        check("collide_err_seq", err_seq, 1'b0);

        // Sequence errors
        do_reset();
        init();
        cmd(ACT, 2'd1, 13'd5);
        nop(2);
        oe_before = oe_cnt;
        rd(2'd2, 6'h10, 2'b00, 16'h0, 1'b0);
        nop(6);
        check("closed_read_no_oe", oe_cnt - oe_before, 0);
        check("closed_read_err_seq", err_seq, 1'b1);
        cmd(ACT, 2'd1, 13'd6);
        nop(2);
        rd(2'd1, 6'h11, 2'b00, 16'h1234);
        nop(6);
        check("seq_err_timing", err_timing, 1'b0);

        // Timing errors: READ one cycle after ACT
        do_reset();
        init();
        cmd(ACT, 2'd0, 13'd0);
        nop(2);
        cmd(WR, 2'd0, 13'h003, 2'b00, 16'hC0DE);
        cmd(PRE, 2'd0, 13'h000);
        check("pre_rcd_err_timing", err_timing, 1'b0);
        cmd(ACT, 2'd0, 13'd0);
        rd(2'd0, 6'h03, 2'b00, 16'hC0DE);
        nop(6);
        check("rcd_err_timing", err_timing, 1'b1);
        check("rcd_err_seq", err_seq, 1'b0);

        // Timing errors: ACT three cycles after REF
        do_reset();
        init();
        cmd(REF, 2'd0, 13'h000);
        nop(2);
        check("pre_rfc_err_timing", err_timing, 1'b0);
        cmd(ACT, 2'd0, 13'd0);
        check("rfc_err_timing", err_timing, 1'b1);
        check("rfc_refresh", refresh_count, 16'd9);

        // CL=2, then reset with a read in flight
        do_reset();
        init();
        cmd(MRS, 2'd0, 13'h020);
        cl_model = 2;
        cmd(ACT, 2'd1, 13'd5);
        nop(2);
        rd(2'd1, 6'h10, 2'b00, 16'hBEAA);
        nop(4);
        rd(2'd1, 6'h11, 2'b00, 16'h0, 1'b0);
        @(posedge clk);
        #2;
        check("inflight_oe", bus.dq_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_oe", bus.dq_oe, 1'b0);
        check("async_rst_dq_out", bus.dq_out, 16'h0);
        check("async_rst_mode_set", mode_set, 1'b0);
        check("async_rst_refresh", refresh_count, 16'd0);
        nop(2);
        rst = 1'b0;
        nop(1);
        // Unsupported mode value leaves CL at its reset value of 3
        cl_model = 3;
        cmd(MRS, 2'd0, 13'h000);
        cmd(ACT, 2'd1, 13'd5);
        nop(2);
        rd(2'd1, 6'h11, 2'b00, 16'h1234);
        nop(6);
        check("bad_mrs_err_mode", err_mode, 1'b1);
        check("bad_mrs_mode_set", mode_set, 1'b1);
        check("bad_mrs_err_seq", err_seq, 1'b0);

        check("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
